// File: rtl/vga_frame_buffer.sv
// 160x120x3 frame buffer with a plot write port, a 1-cycle read port and 640x480@60 VGA scanout (4x4 pixel blocks).
// Define FB_CLEAR_ON_RESET_EN to fill the buffer with BG_COLOUR after every reset.
module vga_frame_buffer #(
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int COLOR_W = 3,
    parameter logic [COLOR_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               plot,
    input  logic [7:0]         x,
    input  logic [6:0]         y,
    input  logic [COLOR_W-1:0] colour,
    input  logic               rd_req,
    input  logic [7:0]         rd_x,
    input  logic [6:0]         rd_y,
    output logic               rd_valid,
    output logic [COLOR_W-1:0] rd_colour,
    output logic               busy,
    output logic               frame_start,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b
);
    localparam int DEPTH = FB_W * FB_H;
    localparam logic [7:0] X_LIM = 8'(FB_W);
    localparam logic [6:0] Y_LIM = 7'(FB_H);

    logic [COLOR_W-1:0] mem [DEPTH];

    // ---------------- port A: plot writes, clear writes, rd_* reads
    logic               wr_ok, rd_in, rd_in_q, a_we;
    logic [14:0]        wr_addr, rd_addr, a_addr;
    logic [COLOR_W-1:0] a_data, a_q;

    assign wr_ok   = plot && !busy && !reset && (x < X_LIM) && (y < Y_LIM);
    assign wr_addr = 15'(y) * 15'(FB_W) + 15'(x);
    assign rd_in   = (rd_x < X_LIM) && (rd_y < Y_LIM);
    assign rd_addr = rd_in ? 15'(rd_y) * 15'(FB_W) + 15'(rd_x) : '0;

`ifdef FB_CLEAR_ON_RESET_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    state_t      state;
    logic [14:0] clr_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_addr == 15'(DEPTH - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 15'd1;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        a_we   = wr_ok;
        a_addr = wr_addr;
        a_data = wr_ok ? colour : BG_COLOUR;
`ifdef FB_CLEAR_ON_RESET_EN
        if (state == S_CLEAR && !reset) begin
            a_we   = 1'b1;
            a_addr = clr_addr;
            a_data = BG_COLOUR;
        end
`endif
    end

    // Read and write share this block so a same-address access returns the old data.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_data;
        a_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_in_q  <= 1'b0;
        end else begin
            rd_valid <= rd_req && !busy;
            rd_in_q  <= rd_in;
        end
    end

    assign rd_colour = (rd_valid && rd_in_q) ? a_q : '0;

    // ---------------- timing generator: counters advance on every other clk
    logic       tick;
    logic [9:0] h_cnt, v_cnt;
    logic       vis, hs_c, vs_c;
    logic       hs_1, vs_1, blank_1;
    logic [14:0]        sc_addr;
    logic [COLOR_W-1:0] sc_q;

    assign vis     = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    assign hs_c    = !((h_cnt >= 10'd656) && (h_cnt < 10'd752));
    assign vs_c    = !((v_cnt >= 10'd490) && (v_cnt < 10'd492));
    assign sc_addr = vis ? 15'(v_cnt[9:2]) * 15'(FB_W) + 15'(h_cnt[9:2]) : '0;

    always_ff @(posedge clk) sc_q <= mem[sc_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            tick        <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
            hs_1        <= 1'b1;
            vs_1        <= 1'b1;
            blank_1     <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            tick        <= ~tick;
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                if (h_cnt == 10'd799) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'd524) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
            // stage 1 lines up with the memory read, stage 2 with the colour register
            hs_1        <= hs_c;
            vs_1        <= vs_c;
            blank_1     <= vis;
            vga_hs      <= hs_1;
            vga_vs      <= vs_1;
            vga_blank_n <= blank_1;
            vga_r       <= blank_1 ? {8{sc_q[COLOR_W-1]}} : 8'h00;
            vga_g       <= blank_1 ? {8{sc_q[COLOR_W-2]}} : 8'h00;
            vga_b       <= blank_1 ? {8{sc_q[COLOR_W-3]}} : 8'h00;
        end
    end
endmodule
